bank1_slot_table: RTL and testbench
===================================

Name: bank1_slot_table

Overview:
- Bank1 descriptor store: 2^BANK1_INDEX_WIDTH slots, each holding src_addr, src_size, des_addr, des_size, status and a profile cycle counter.
- Sits directly downstream of the AXI read slave, serving its ext_bank1_out_* request/data port.
- Also accepts field writes from the AXI write slave.
- Also exposes a fetch/start/done port to the sequencer core, which runs slots and timestamps them.

Parameters:
- BANK1_INDEX_WIDTH, 2: slot index width; slot count = 2^BANK1_INDEX_WIDTH.
- BANK1_SRC_ADDR_WIDTH, 32: source address field width.
- BANK1_SRC_SIZE_WIDTH, 26: source size field width.
- BANK1_DST_ADDR_WIDTH, 32: destination address field width.
- BANK1_DST_SIZE_WIDTH, 26: destination size field width.
- BANK1_STATUS_WIDTH, 2: slot status width.
- BANK1_PROFILE_WIDTH, 32: profile counter width.
- DATA_WIDTH, 32: AXI write data width.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- ext_bank1_out_index  in  BANK1_INDEX_WIDTH  read slot select.
- ext_bank1_out_req  in  1  read request.
- ext_bank1_out_src_addr / _src_size / _des_addr / _des_size / _status / _profile  out  field widths  selected slot contents.
- ext_bank1_out_ready  out  1  read data valid.
- ext_bank1_in_req  in  1  single-cycle write strobe.
- ext_bank1_in_index  in  BANK1_INDEX_WIDTH  write slot.
- ext_bank1_in_offset  in  4  field select: 0 src_addr, 1 src_size, 2 des_addr, 3 des_size, 4 status, 5 profile.
- ext_bank1_in_data  in  DATA_WIDTH  write data.
- seq_index  in  BANK1_INDEX_WIDTH  sequencer slot select.
- seq_fetch  in  1  fetch descriptor request.
- seq_fetch_valid  out  1  fetched descriptor valid.
- seq_src_addr / seq_src_size / seq_des_addr / seq_des_size  out  field widths  registered fetched descriptor.
- seq_start  in  1  pulse: slot at seq_index begins running.
- seq_done  in  1  pulse: slot at seq_index finished.
- seq_err  out  1  one-cycle pulse on an illegal sequencer event.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all slot fields, status and profile are 0; seq_fetch_valid, seq_err and all seq_* data outputs are 0.
- Status encoding: 0 IDLE, 1 VALID, 2 RUNNING, 3 DONE.
- Read port:
  - Combinational mux of registered storage selected by ext_bank1_out_index.
  - ext_bank1_out_ready = ext_bank1_out_req, with zero latency.
  - Outputs show current register contents regardless of req.
  - A read in the same cycle as a write to that slot returns the pre-write value.
- Write port:
  - On ext_bank1_in_req, the field at offset is written at the clock edge.
  - Size fields take the low BANK1_*_SIZE_WIDTH bits.
  - Status write (offset 4): data[1:0] = 0 sets IDLE; = 1 sets VALID; values 2 and 3 are ignored.
  - Status write while the slot is RUNNING is ignored.
  - Profile write (offset 5) clears the counter to 0 regardless of data.
  - Offsets 6–15 are ignored.
- Fetch:
  - seq_fetch in cycle N makes seq_src_addr..seq_des_size the slot[seq_index] contents, registered, with seq_fetch_valid = 1 in cycle N+1 only.
  - Data holds until the next fetch.
  - Back-to-back fetches are allowed, one per cycle.
- Slot state machine (per slot):
  - IDLE -> VALID: AXI status write 1.
  - VALID -> RUNNING: seq_start at that index; the profile is cleared to 0 in the same edge.
  - RUNNING -> DONE: seq_done at that index.
  - DONE/VALID -> IDLE or VALID: AXI status write.
- Illegal sequencer events: seq_start on a non-VALID slot, or seq_done on a non-RUNNING slot, cause no state change and seq_err = 1 in the next cycle.
- seq_start and seq_done asserted together: treated as illegal; no change; seq_err.
- Profile:
  - Each slot in RUNNING increments its counter by 1 per cycle.
  - The counter saturates at all-ones; no wrap.
  - It holds its value in every other state.
- Collisions: seq_start/seq_done and an AXI write to the same slot in the same cycle:
  - For status/profile, the sequencer event wins and the AXI write is dropped.
  - AXI writes to offsets 0–3 still take effect.
- Reset mid-run: any RUNNING slot returns to IDLE with profile 0 at the reset edge; no seq_err is generated.

Test Plan:
- Reset, then read slots 0–3 with req=1 -> every field reads 0 and ready=1 each cycle.
- Write slot 2 with src_addr=0x80001000, src_size=0xFFFFFFFF, then status=1 -> read returns src_size=0x3FFFFFF and status=1.
- Fetch slot 2 in cycle N -> seq_fetch_valid=1 in N+1 only, seq_src_addr=0x80001000.
- With slot 2 VALID, pulse seq_start, wait 10 cycles, pulse seq_done -> status=3 and profile=10 (increments counted while RUNNING; the edge that takes the slot to DONE does not increment).
- seq_start on slot 1 (IDLE) -> seq_err one cycle, status stays 0; seq_start on slot 2 with a same-cycle AXI status write 0 -> slot RUNNING, write dropped.
- Preload profile near all-ones via a long run (or a reduced-width build with BANK1_PROFILE_WIDTH=4), run 20 cycles -> counter holds 0xF; assert reset mid-run -> status=0 and profile=0 next cycle.

Source files
------------

// File: rtl/bank1_slot_table.sv
// bank1_slot_table: bank1 descriptor slots with AXI read/write ports and a
// sequencer fetch/start/done port that runs and profiles slots.
module bank1_slot_table #(
   parameter int BANK1_INDEX_WIDTH    = 2,
   parameter int BANK1_SRC_ADDR_WIDTH = 32,
   parameter int BANK1_SRC_SIZE_WIDTH = 26,
   parameter int BANK1_DST_ADDR_WIDTH = 32,
   parameter int BANK1_DST_SIZE_WIDTH = 26,
   parameter int BANK1_STATUS_WIDTH   = 2,
   parameter int BANK1_PROFILE_WIDTH  = 32,
   parameter int DATA_WIDTH           = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [BANK1_INDEX_WIDTH-1:0]    ext_bank1_out_index,
   input  logic                            ext_bank1_out_req,
   output logic [BANK1_SRC_ADDR_WIDTH-1:0] ext_bank1_out_src_addr,
   output logic [BANK1_SRC_SIZE_WIDTH-1:0] ext_bank1_out_src_size,
   output logic [BANK1_DST_ADDR_WIDTH-1:0] ext_bank1_out_des_addr,
   output logic [BANK1_DST_SIZE_WIDTH-1:0] ext_bank1_out_des_size,
   output logic [BANK1_STATUS_WIDTH-1:0]   ext_bank1_out_status,
   output logic [BANK1_PROFILE_WIDTH-1:0]  ext_bank1_out_profile,
   output logic                            ext_bank1_out_ready,
   input  logic                            ext_bank1_in_req,
   input  logic [BANK1_INDEX_WIDTH-1:0]    ext_bank1_in_index,
   input  logic [3:0]                      ext_bank1_in_offset,
   input  logic [DATA_WIDTH-1:0]           ext_bank1_in_data,
   input  logic [BANK1_INDEX_WIDTH-1:0]    seq_index,
   input  logic                            seq_fetch,
   output logic                            seq_fetch_valid,
   output logic [BANK1_SRC_ADDR_WIDTH-1:0] seq_src_addr,
   output logic [BANK1_SRC_SIZE_WIDTH-1:0] seq_src_size,
   output logic [BANK1_DST_ADDR_WIDTH-1:0] seq_des_addr,
   output logic [BANK1_DST_SIZE_WIDTH-1:0] seq_des_size,
   input  logic                            seq_start,
   input  logic                            seq_done,
   output logic                            seq_err
);
   localparam int SLOTS = 2 ** BANK1_INDEX_WIDTH;
   localparam logic [BANK1_STATUS_WIDTH-1:0] ST_VALID   = BANK1_STATUS_WIDTH'(1);
   localparam logic [BANK1_STATUS_WIDTH-1:0] ST_RUNNING = BANK1_STATUS_WIDTH'(2);
   localparam logic [BANK1_STATUS_WIDTH-1:0] ST_DONE    = BANK1_STATUS_WIDTH'(3);
   logic [BANK1_SRC_ADDR_WIDTH-1:0] src_addr [SLOTS];
   logic [BANK1_SRC_SIZE_WIDTH-1:0] src_size [SLOTS];
   logic [BANK1_DST_ADDR_WIDTH-1:0] des_addr [SLOTS];
   logic [BANK1_DST_SIZE_WIDTH-1:0] des_size [SLOTS];
   logic [BANK1_STATUS_WIDTH-1:0]   status   [SLOTS];
   logic [BANK1_PROFILE_WIDTH-1:0]  profile  [SLOTS];
   logic seq_hit, seq_bad, wr_status, wr_profile;
   assign ext_bank1_out_src_addr = src_addr[ext_bank1_out_index];
   assign ext_bank1_out_src_size = src_size[ext_bank1_out_index];
   assign ext_bank1_out_des_addr = des_addr[ext_bank1_out_index];
   assign ext_bank1_out_des_size = des_size[ext_bank1_out_index];
   assign ext_bank1_out_status   = status[ext_bank1_out_index];
   assign ext_bank1_out_profile  = profile[ext_bank1_out_index];
   assign ext_bank1_out_ready    = ext_bank1_out_req;
   // Any sequencer event on the written slot shadows AXI status/profile writes.
   assign seq_hit    = (seq_start || seq_done) && ext_bank1_in_index == seq_index;
   assign seq_bad    = (seq_start && seq_done) || (seq_start && status[seq_index] != ST_VALID) ||
                       (seq_done && status[seq_index] != ST_RUNNING);
   assign wr_status  = ext_bank1_in_req && ext_bank1_in_offset == 4'd4 && !seq_hit &&
                       status[ext_bank1_in_index] != ST_RUNNING && !ext_bank1_in_data[1];
   assign wr_profile = ext_bank1_in_req && ext_bank1_in_offset == 4'd5 && !seq_hit;
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SLOTS; s++) begin
            src_addr[s] <= '0;
            src_size[s] <= '0;
            des_addr[s] <= '0;
            des_size[s] <= '0;
            status[s]   <= '0;
            profile[s]  <= '0;
         end
         seq_fetch_valid <= 1'b0;
         seq_src_addr    <= '0;
         seq_src_size    <= '0;
         seq_des_addr    <= '0;
         seq_des_size    <= '0;
         seq_err         <= 1'b0;
      end else begin
         seq_fetch_valid <= seq_fetch;
         seq_err         <= seq_bad;
         if (seq_fetch) begin
            seq_src_addr <= src_addr[seq_index];
            seq_src_size <= src_size[seq_index];
            seq_des_addr <= des_addr[seq_index];
            seq_des_size <= des_size[seq_index];
         end
         for (int s = 0; s < SLOTS; s++)
            if (status[s] == ST_RUNNING && profile[s] != '1) profile[s] <= profile[s] + 1'b1;
         if (ext_bank1_in_req && ext_bank1_in_offset == 4'd0)
            src_addr[ext_bank1_in_index] <= BANK1_SRC_ADDR_WIDTH'(ext_bank1_in_data);
         if (ext_bank1_in_req && ext_bank1_in_offset == 4'd1)
            src_size[ext_bank1_in_index] <= BANK1_SRC_SIZE_WIDTH'(ext_bank1_in_data);
         if (ext_bank1_in_req && ext_bank1_in_offset == 4'd2)
            des_addr[ext_bank1_in_index] <= BANK1_DST_ADDR_WIDTH'(ext_bank1_in_data);
         if (ext_bank1_in_req && ext_bank1_in_offset == 4'd3)
            des_size[ext_bank1_in_index] <= BANK1_DST_SIZE_WIDTH'(ext_bank1_in_data);
         if (wr_status) status[ext_bank1_in_index] <= BANK1_STATUS_WIDTH'(ext_bank1_in_data[1:0]);
         if (wr_profile) profile[ext_bank1_in_index] <= '0;
         if (seq_start && !seq_bad) begin
            status[seq_index]  <= ST_RUNNING;
            profile[seq_index] <= '0;
         end
         // The edge that finishes a run must not count as a running cycle.
         if (seq_done && !seq_bad) begin
            status[seq_index]  <= ST_DONE;
            profile[seq_index] <= profile[seq_index];
         end
      end
   end
endmodule

// File: tb/tb_bank1_slot_table.sv
// tb_bank1_slot_table: directed plan checks plus a long randomized run against
// a slot-level behavioural model of the descriptor table.
module tb_bank1_slot_table;
   localparam int IDLE = 0, VALID = 1, RUNNING = 2, DONE = 3;
   logic clk = 0, reset = 1;
   logic [1:0]  out_index = 0, in_index = 0, seq_index = 0;
   logic        out_req = 0, in_req = 0, seq_fetch = 0, seq_start = 0, seq_done = 0;
   logic [3:0]  in_offset = 0;
   logic [31:0] in_data = 0;
   logic [31:0] o_sa, o_da, o_pf, s_sa, s_da, q_sa, q_da;
   logic [25:0] o_ss, o_ds, s_ss, s_ds, q_ss, q_ds;
   logic [1:0]  o_st, q_st;
   logic [3:0]  q_pf;
   logic        o_rdy, s_fv, s_err, q_rdy, q_fv, q_err;
   logic [31:0] m_sa [4], m_da [4], m_pf [4], n_sa [4], n_da [4], n_pf [4];
   logic [25:0] m_ss [4], m_ds [4], n_ss [4], n_ds [4];
   int          m_st [4], n_st [4];
   logic [31:0] e_sa, e_da, x_sa, x_da;
   logic [25:0] e_ss, e_ds, x_ss, x_ds;
   logic        e_fv, e_err, x_fv, x_err;
   int checks = 0, passed = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   bank1_slot_table dut (
      .clk(clk), .reset(reset),
      .ext_bank1_out_index(out_index), .ext_bank1_out_req(out_req),
      .ext_bank1_out_src_addr(o_sa), .ext_bank1_out_src_size(o_ss),
      .ext_bank1_out_des_addr(o_da), .ext_bank1_out_des_size(o_ds),
      .ext_bank1_out_status(o_st), .ext_bank1_out_profile(o_pf), .ext_bank1_out_ready(o_rdy),
      .ext_bank1_in_req(in_req), .ext_bank1_in_index(in_index),
      .ext_bank1_in_offset(in_offset), .ext_bank1_in_data(in_data),
      .seq_index(seq_index), .seq_fetch(seq_fetch), .seq_fetch_valid(s_fv),
      .seq_src_addr(s_sa), .seq_src_size(s_ss), .seq_des_addr(s_da), .seq_des_size(s_ds),
      .seq_start(seq_start), .seq_done(seq_done), .seq_err(s_err));

   // Narrow-profile copy sharing all stimulus, used only to observe saturation.
   bank1_slot_table #(.BANK1_PROFILE_WIDTH(4)) dut_p4 (
      .clk(clk), .reset(reset),
      .ext_bank1_out_index(out_index), .ext_bank1_out_req(out_req),
      .ext_bank1_out_src_addr(q_sa), .ext_bank1_out_src_size(q_ss),
      .ext_bank1_out_des_addr(q_da), .ext_bank1_out_des_size(q_ds),
      .ext_bank1_out_status(q_st), .ext_bank1_out_profile(q_pf), .ext_bank1_out_ready(q_rdy),
      .ext_bank1_in_req(in_req), .ext_bank1_in_index(in_index),
      .ext_bank1_in_offset(in_offset), .ext_bank1_in_data(in_data),
      .seq_index(seq_index), .seq_fetch(seq_fetch), .seq_fetch_valid(q_fv),
      .seq_src_addr(), .seq_src_size(), .seq_des_addr(), .seq_des_size(),
      .seq_start(seq_start), .seq_done(seq_done), .seq_err(q_err));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Next model state from the current model state and the driven inputs.
   task automatic model_next();
      bit bad, shadow;
      int si = int'(seq_index), wi = int'(in_index);
      for (int s = 0; s < 4; s++) begin
         n_sa[s] = m_sa[s]; n_ss[s] = m_ss[s]; n_da[s] = m_da[s]; n_ds[s] = m_ds[s];
         n_st[s] = m_st[s];
         n_pf[s] = (m_st[s] == RUNNING && m_pf[s] != 32'hFFFF_FFFF) ? m_pf[s] + 1 : m_pf[s];
      end
      x_sa = e_sa; x_ss = e_ss; x_da = e_da; x_ds = e_ds;
      bad = (seq_start && seq_done) || (seq_start && m_st[si] != VALID) ||
            (seq_done && m_st[si] != RUNNING);
      shadow = (seq_start || seq_done) && si == wi;
      if (in_req) begin
         if (in_offset == 0) n_sa[wi] = in_data;
         if (in_offset == 1) n_ss[wi] = in_data[25:0];
         if (in_offset == 2) n_da[wi] = in_data;
         if (in_offset == 3) n_ds[wi] = in_data[25:0];
         if (in_offset == 4 && !shadow && m_st[wi] != RUNNING && in_data[1:0] < 2)
            n_st[wi] = int'(in_data[1:0]);
         if (in_offset == 5 && !shadow) n_pf[wi] = 0;
      end
      if (seq_start && !bad) begin n_st[si] = RUNNING; n_pf[si] = 0; end
      if (seq_done && !bad) begin n_st[si] = DONE; n_pf[si] = m_pf[si]; end
      x_err = (seq_start || seq_done) && bad;
      x_fv = seq_fetch;
      if (seq_fetch) begin x_sa = m_sa[si]; x_ss = m_ss[si]; x_da = m_da[si]; x_ds = m_ds[si]; end
      if (reset) begin
         for (int s = 0; s < 4; s++) begin
            n_sa[s] = 0; n_ss[s] = 0; n_da[s] = 0; n_ds[s] = 0; n_st[s] = IDLE; n_pf[s] = 0;
         end
         x_sa = 0; x_ss = 0; x_da = 0; x_ds = 0; x_fv = 0; x_err = 0;
      end
   endtask

   task automatic step();
      model_next();
      @(posedge clk);
      m_sa = n_sa; m_ss = n_ss; m_da = n_da; m_ds = n_ds; m_st = n_st; m_pf = n_pf;
      e_sa = x_sa; e_ss = x_ss; e_da = x_da; e_ds = x_ds; e_fv = x_fv; e_err = x_err;
      @(negedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] idx, input logic [3:0] off, input logic [31:0] d);
      in_req = 1; in_index = idx; in_offset = off; in_data = d;
      step();
      in_req = 0;
   endtask

   always @(negedge clk) if (chk_en) begin
      chk("rd_src_addr", o_sa, m_sa[out_index]);
      chk("rd_src_size", o_ss, m_ss[out_index]);
      chk("rd_des_addr", o_da, m_da[out_index]);
      chk("rd_des_size", o_ds, m_ds[out_index]);
      chk("rd_status", o_st, m_st[out_index]);
      chk("rd_profile", o_pf, m_pf[out_index]);
      chk("rd_ready", o_rdy, out_req);
      chk("fetch_valid", s_fv, e_fv);
      chk("fetch_src_addr", s_sa, e_sa);
      chk("fetch_src_size", s_ss, e_ss);
      chk("fetch_des_addr", s_da, e_da);
      chk("fetch_des_size", s_ds, e_ds);
      chk("seq_err", s_err, e_err);
   end

   initial begin
      step(); step();
      reset = 0;
      chk_en = 1;
      out_req = 1;
      for (int s = 0; s < 4; s++) begin
         out_index = 2'(s);
         #1;
         chk("reset_src_addr", o_sa, 0); chk("reset_src_size", o_ss, 0);
         chk("reset_des_addr", o_da, 0); chk("reset_des_size", o_ds, 0);
         chk("reset_status", o_st, 0); chk("reset_profile", o_pf, 0);
         chk("reset_ready", o_rdy, 1);
      end
      chk("reset_fetch_valid", s_fv, 0);
      chk("reset_seq_err", s_err, 0);
      wr(2, 0, 32'h8000_1000);
      wr(2, 1, 32'hFFFF_FFFF);
      wr(2, 4, 1);
      out_index = 2;
      #1;
      chk("wr_src_addr", o_sa, 32'h8000_1000);
      chk("wr_src_size_trunc", o_ss, 26'h3FF_FFFF);
      chk("wr_status_valid", o_st, 1);
      seq_index = 2; seq_fetch = 1;
      step();
      seq_fetch = 0;
      chk("fetch_n1_valid", s_fv, 1);
      chk("fetch_n1_src_addr", s_sa, 32'h8000_1000);
      chk("fetch_n1_src_size", s_ss, 26'h3FF_FFFF);
      step();
      chk("fetch_n2_valid", s_fv, 0);
      chk("fetch_hold_src_addr", s_sa, 32'h8000_1000);
      seq_start = 1;
      step();
      seq_start = 0;
      repeat (10) step();
      seq_done = 1;
      step();
      seq_done = 0;
      chk("run_status_done", o_st, 3);
      chk("run_profile_10", o_pf, 10);
      chk("model_profile_10", m_pf[2], 10);
      seq_index = 1; seq_start = 1;
      step();
      seq_start = 0; out_index = 1;
      #1;
      chk("illegal_start_err", s_err, 1);
      chk("illegal_start_status", o_st, 0);
      step();
      chk("illegal_err_one_cycle", s_err, 0);
      wr(2, 4, 1);
      seq_index = 2; seq_start = 1;
      wr(2, 4, 0);
      seq_start = 0; out_index = 2;
      #1;
      chk("collision_running", o_st, 2);
      seq_done = 1;
      step();
      seq_done = 0;
      wr(2, 4, 1);
      seq_start = 1;
      step();
      seq_start = 0;
      repeat (20) step();
      chk("sat_wide_profile", o_pf, 20);
      chk("sat_narrow_profile", q_pf, 4'hF);
      chk("sat_narrow_status", q_st, 2);
      reset = 1;
      step();
      reset = 0;
      chk("midrun_reset_status", o_st, 0);
      chk("midrun_reset_profile", o_pf, 0);
      chk("midrun_reset_p4_profile", q_pf, 0);
      chk("midrun_reset_err", s_err, 0);
      for (int c = 0; c < 4000; c++) begin
         reset     = ($urandom_range(0, 299) == 0);
         out_index = 2'($urandom);
         out_req   = 1'($urandom);
         in_req    = ($urandom_range(0, 2) == 0);
         in_index  = 2'($urandom);
         in_offset = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(4, 5));
         in_data   = (in_offset == 4) ? 32'($urandom_range(0, 3)) : $urandom;
         seq_index = 2'($urandom);
         seq_fetch = 1'($urandom);
         seq_start = ($urandom_range(0, 3) == 0);
         seq_done  = ($urandom_range(0, 4) == 0);
         step();
      end
      chk_en = 0;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
